// File: rtl/coin_input_conditioner.sv
// Synchronizes and debounces the dime, nickel and dispense buttons, turns each press into one
// pulse, and queues coin presses toward the vending FSM. Optional macro: COIN_INHIBIT_EN.
module coin_input_conditioner #(
   parameter int DB_CYCLES = 250000,
   parameter int CNT_W     = 18
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dime,
   input  logic       nickel,
   input  logic       dispense_btn,
   input  logic       coin_ready,
`ifdef COIN_INHIBIT_EN
   input  logic       coin_inhibit,
   output logic       reject_pulse,
`endif
   output logic       coin_valid,
   output logic [4:0] coin_value,
   output logic       dime_pulse,
   output logic       nickel_pulse,
   output logic       dispense_pulse,
   output logic       overrun
);

   localparam int               NCH        = 3;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [4:0]       VAL_DIME   = 5'd10;
   localparam logic [4:0]       VAL_NICKEL = 5'd5;

   // Channel order: bit 0 dime, bit 1 nickel, bit 2 dispense.
   logic [NCH-1:0]   raw;
   logic [NCH-1:0]   s1_q, s1_d;
   logic [NCH-1:0]   s2_q, s2_d;
   logic [NCH-1:0]   stable_q, stable_d;
   logic [NCH-1:0]   stable_dly_q, stable_dly_d;
   logic [NCH-1:0]   pulse_q, pulse_d;
   logic [NCH-1:0]   rise;
   logic [CNT_W-1:0] cnt_q [NCH];
   logic [CNT_W-1:0] cnt_d [NCH];

   logic [1:0]       dime_pend_q, dime_pend_d;
   logic [1:0]       nickel_pend_q, nickel_pend_d;
   logic             coin_valid_q, coin_valid_d;
   logic [4:0]       coin_value_q, coin_value_d;
   logic             overrun_q, overrun_d;
   logic             reject_q, reject_d;

   logic             inhibit;
   logic             load;
   logic             dime_take, nickel_take;
   logic             dime_inc, nickel_inc;
   logic             dime_drop, nickel_drop;

   assign raw = {dispense_btn, nickel, dime};

`ifdef COIN_INHIBIT_EN
   assign inhibit = coin_inhibit;
`else
   assign inhibit = 1'b0;
`endif

   // The counter runs to DB_CYCLES so that stable moves DB_CYCLES+2 edges after the raw
   // level is first sampled; any cycle with s2 back at the stable level restarts it.
   always_comb begin : sync_debounce
      s1_d         = raw;
      s2_d         = s1_q;
      stable_d     = stable_q;
      stable_dly_d = stable_q;
      for (int i = 0; i < NCH; i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               stable_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
      rise    = stable_q & ~stable_dly_q;
      pulse_d = rise;
   end

   always_comb begin : coin_queue
      load        = ~coin_valid_q | coin_ready;
      dime_take   = load & (dime_pend_q != 2'd0);
      nickel_take = load & (dime_pend_q == 2'd0) & (nickel_pend_q != 2'd0);
      dime_inc    = rise[0] & ~inhibit;
      nickel_inc  = rise[1] & ~inhibit;
      // A press into a full count is lost unless a coin leaves the same edge.
      dime_drop   = dime_inc & ~dime_take & (dime_pend_q == 2'd3);
      nickel_drop = nickel_inc & ~nickel_take & (nickel_pend_q == 2'd3);

      dime_pend_d = dime_pend_q;
      if (dime_inc & ~dime_take & ~dime_drop) begin
         dime_pend_d = dime_pend_q + 2'd1;
      end else if (~dime_inc & dime_take) begin
         dime_pend_d = dime_pend_q - 2'd1;
      end

      nickel_pend_d = nickel_pend_q;
      if (nickel_inc & ~nickel_take & ~nickel_drop) begin
         nickel_pend_d = nickel_pend_q + 2'd1;
      end else if (~nickel_inc & nickel_take) begin
         nickel_pend_d = nickel_pend_q - 2'd1;
      end

      overrun_d = overrun_q | dime_drop | nickel_drop;

      coin_valid_d = coin_valid_q;
      coin_value_d = coin_value_q;
      if (load) begin
         coin_valid_d = dime_take | nickel_take;
         if (dime_take) begin
            coin_value_d = VAL_DIME;
         end else if (nickel_take) begin
            coin_value_d = VAL_NICKEL;
         end else begin
            coin_value_d = 5'd0;
         end
      end

      reject_d = (rise[0] | rise[1]) & inhibit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q          <= '0;
         s2_q          <= '0;
         stable_q      <= '0;
         stable_dly_q  <= '0;
         pulse_q       <= '0;
         dime_pend_q   <= '0;
         nickel_pend_q <= '0;
         coin_valid_q  <= 1'b0;
         coin_value_q  <= '0;
         overrun_q     <= 1'b0;
         reject_q      <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q          <= s1_d;
         s2_q          <= s2_d;
         stable_q      <= stable_d;
         stable_dly_q  <= stable_dly_d;
         pulse_q       <= pulse_d;
         dime_pend_q   <= dime_pend_d;
         nickel_pend_q <= nickel_pend_d;
         coin_valid_q  <= coin_valid_d;
         coin_value_q  <= coin_value_d;
         overrun_q     <= overrun_d;
         reject_q      <= reject_d;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign coin_valid     = coin_valid_q;
   assign coin_value     = coin_value_q;
   assign dime_pulse     = pulse_q[0];
   assign nickel_pulse   = pulse_q[1];
   assign dispense_pulse = pulse_q[2];
   assign overrun        = overrun_q;

`ifdef COIN_INHIBIT_EN
   assign reject_pulse = reject_q;
`else
   logic unused_reject;
   assign unused_reject = reject_q;
`endif

endmodule
